// File: rtl/uart_freq_cmd_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_freq_cmd_if                                           |
// | Description : Bundle between the host-side UART pair / NCO and the       |
// |               uart_freq_cmd byte parser.                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface uart_freq_cmd_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic [63:0] o_phase_inc;
  logic        o_phase_valid;
  logic        o_busy;
  logic        o_err;

  // Environment side: feeds receiver/transmitter status, consumes results.
  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_phase_inc, o_phase_valid, o_busy, o_err
  );

  // Parser side.
  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_phase_inc, o_phase_valid, o_busy, o_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_freq_cmd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_freq_cmd                                              |
// | Description : UART byte command parser. 'F' + 8 bytes loads a 64-bit     |
// |               NCO phase increment (acked with ACK_BYTE), 'Q' reads the   |
// |               current increment back MSB byte first.                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_freq_cmd #(
  parameter logic [63:0] DEFAULT_INC  = 64'h000000204B013556,
  parameter int unsigned TIMEOUT_CLKS = 115500,
  parameter logic [7:0]  ACK_BYTE     = 8'h4B
) (
  input  wire logic      osc_clk,
  input  wire logic      reset,
  uart_freq_cmd_if.slave bus
);

  // Counter only needs to hold TIMEOUT_CLKS-1.
  localparam int unsigned c_TW      = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] c_CMD_F = 8'h46;
  localparam logic [7:0] c_CMD_Q = 8'h51;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LOAD    = 3'd1;
  localparam logic [2:0] c_COMMIT  = 3'd2;
  localparam logic [2:0] c_TX_SEND = 3'd3;
  localparam logic [2:0] c_TX_WAIT = 3'd4;

  logic [2:0]      state_q,  state_d;
  logic [2:0]      bcnt_q,   bcnt_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [c_TW-1:0] tcnt_q,   tcnt_d;
  logic [63:0]     phase_q,  phase_d;
  logic [63:0]     txsh_q,   txsh_d;
  logic [3:0]      txcnt_q,  txcnt_d;
  logic [7:0]      txbyte_q, txbyte_d;

  logic w_send;
  logic w_timeout;
  logic [63:0] w_shift_in;

  assign w_send     = (state_q == c_TX_SEND) && !bus.i_Tx_Active;
  assign w_timeout  = (state_q == c_LOAD) && (tcnt_q == c_TO_LAST) && !bus.i_Rx_DV;
  assign w_shift_in = {shadow_q[55:0], bus.i_Rx_Byte};

  // Next-state logic for the command FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shadow_d = shadow_q;
    tcnt_d   = tcnt_q;
    phase_d  = phase_q;
    txsh_d   = txsh_q;
    txcnt_d  = txcnt_q;
    txbyte_d = txbyte_q;
    case (state_q)
      c_IDLE: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte == c_CMD_F) begin
            state_d  = c_LOAD;
            bcnt_d   = 3'd0;
            tcnt_d   = '0;
            shadow_d = 64'h0;
          end else if (bus.i_Rx_Byte == c_CMD_Q) begin
            txsh_d  = phase_q;
            txcnt_d = 4'd8;
            state_d = c_TX_SEND;
          end
        end
      end
      c_LOAD: begin
        if (bus.i_Rx_DV) begin
          // A byte landing on the timeout cycle still counts.
          shadow_d = w_shift_in;
          bcnt_d   = bcnt_q + 3'd1;
          tcnt_d   = '0;
          if (bcnt_q == 3'd7) begin
            // Increment is written as a whole on the 8th byte, so the
            // COMMIT cycle already presents the new value with its strobe.
            phase_d = w_shift_in;
            state_d = c_COMMIT;
          end
        end else if (w_timeout) begin
          state_d  = c_IDLE;
          shadow_d = 64'h0;
          bcnt_d   = 3'd0;
          tcnt_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      c_COMMIT: begin
        txsh_d  = {ACK_BYTE, 56'h0};
        txcnt_d = 4'd1;
        state_d = c_TX_SEND;
      end
      c_TX_SEND: begin
        if (w_send) begin
          txbyte_d = txsh_q[63:56];
          txsh_d   = {txsh_q[55:0], 8'h00};
          state_d  = c_TX_WAIT;
        end
      end
      c_TX_WAIT: begin
        if (bus.i_Tx_Done) begin
          txcnt_d = txcnt_q - 4'd1;
          state_d = (txcnt_q == 4'd1) ? c_IDLE : c_TX_SEND;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      bcnt_q   <= 3'd0;
      shadow_q <= 64'h0;
      tcnt_q   <= '0;
      phase_q  <= DEFAULT_INC;
      txsh_q   <= 64'h0;
      txcnt_q  <= 4'd0;
      txbyte_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shadow_q <= shadow_d;
      tcnt_q   <= tcnt_d;
      phase_q  <= phase_d;
      txsh_q   <= txsh_d;
      txcnt_q  <= txcnt_d;
      txbyte_q <= txbyte_d;
    end
  end

  // Strobes are decoded from state so the DV pulse lands in the first idle
  // cycle of the transmitter; the byte output holds the last sent value.
  assign bus.o_Tx_DV       = w_send;
  assign bus.o_Tx_Byte     = w_send ? txsh_q[63:56] : txbyte_q;
  assign bus.o_phase_inc   = phase_q;
  assign bus.o_phase_valid = (state_q == c_COMMIT);
  assign bus.o_busy        = (state_q != c_IDLE);
  assign bus.o_err         = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_freq_cmd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_freq_cmd                                           |
// | Description : Self-checking bench for uart_freq_cmd with a host driver, |
// |               a uart_tx responder and a command-level reference model.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_freq_cmd;
  localparam int unsigned TO      = 1000;
  localparam logic [63:0] DEF_INC = 64'h000000204B013556;
  localparam logic [7:0]  ACK     = 8'h4B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_freq_cmd_if bus();
  logic resp_act  = 1'b0;
  logic hold_act  = 1'b0;
  logic resp_busy = 1'b0;
  assign bus.i_Tx_Active = resp_act | hold_act;

  uart_freq_cmd #(
    .DEFAULT_INC (DEF_INC),
    .TIMEOUT_CLKS(TO),
    .ACK_BYTE    (ACK)
  ) dut (
    .osc_clk(clk),
    .reset  (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: current increment and expected reply bytes.
  logic [63:0] model_inc = DEF_INC;
  logic [7:0]  exp_tx[$];

  // Observations gathered by the monitor.
  logic [7:0] got_tx[$];
  int         got_tx_cyc[$];
  int         n_pv = 0, pv_cyc = -1, n_err = 0, err_cyc = -1;
  bit         outstanding = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: sample outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 1'b0;
      end else begin
        if (bus.i_Tx_Done) outstanding = 1'b0;
        if (bus.o_phase_valid) begin n_pv++; pv_cyc = cyc; end
        if (bus.o_err) begin n_err++; err_cyc = cyc; end
        if (bus.o_Tx_DV) begin
          check("dv_while_active", bus.i_Tx_Active, 0);
          check("dv_before_done", outstanding, 0);
          check("dv_with_valid", bus.o_phase_valid, 0);
          outstanding = 1'b1;
          got_tx.push_back(bus.o_Tx_Byte);
          got_tx_cyc.push_back(cyc);
        end
      end
    end
  end

  // uart_tx stand-in: goes active after a DV, stays busy a few cycles, then Done.
  initial begin
    bus.i_Tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_Tx_DV && !rst) begin
        resp_busy = 1'b1;
        @(posedge clk); #1 resp_act = 1'b1;
        repeat ($urandom_range(2, 12)) @(posedge clk);
        #1 resp_act = 1'b0; bus.i_Tx_Done = 1'b1;
        @(posedge clk); #1 bus.i_Tx_Done = 1'b0; resp_busy = 1'b0;
      end
    end
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // One host byte strobe; the next strobe is `gap` cycles later (gap >= 2).
  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    @(posedge clk); #1;
    bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = b; t = cyc;
    @(posedge clk); #1;
    bus.i_Rx_DV = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while ((bus.o_busy || resp_busy) && k < 20000) begin
      @(negedge clk); k++;
    end
    check({tag, "_idle"}, (k < 20000), 1);
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_count"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      check({tag, "_byte"}, (i < got_tx.size()) ? {56'h0, got_tx[i]} : 64'hDEAD, exp_tx[i]);
  endtask

  // 'F' + 8 bytes; byte index long_idx (0..7, -1 none) is followed by a gap
  // of exactly TO cycles, which is the last cycle a byte may still arrive.
  task automatic cmd_load(input logic [63:0] v, input int gmax, input int long_idx,
                          output int t_last);
    int t;
    send_byte(8'h46, $urandom_range(2, gmax), t);
    for (int i = 0; i < 8; i++)
      send_byte(v[(7-i)*8 +: 8], (i == 7) ? 2 : ((i == long_idx) ? TO : $urandom_range(2, gmax)), t);
    t_last = t;
    model_inc = v;
  endtask

  task automatic load_and_check(input string tag, input logic [63:0] v, input int gmax,
                                input int long_idx);
    int t_last, pv0, err0;
    pv0 = n_pv; err0 = n_err;
    got_tx.delete(); got_tx_cyc.delete();
    cmd_load(v, gmax, long_idx, t_last);
    wait_idle(tag);
    check({tag, "_pv_count"}, n_pv - pv0, 1);
    check({tag, "_pv_latency"}, pv_cyc, t_last + 1);
    check({tag, "_no_err"}, n_err - err0, 0);
    check({tag, "_phase"}, bus.o_phase_inc, model_inc);
    check({tag, "_ack_latency"}, (got_tx_cyc.size() > 0) ? got_tx_cyc[0] : -1, t_last + 2);
    exp_tx.delete(); exp_tx.push_back(ACK);
    compare_tx({tag, "_ack"});
  endtask

  task automatic query_and_check(input string tag, input bit junk);
    int t;
    got_tx.delete(); got_tx_cyc.delete();
    send_byte(8'h51, 4, t);
    if (junk) send_byte(8'h46, 2, t);   // dropped: block is busy
    wait_idle(tag);
    exp_tx.delete();
    for (int i = 7; i >= 0; i--) exp_tx.push_back(model_inc[i*8 +: 8]);
    compare_tx(tag);
  endtask

  initial begin
    int t, t0, rel, pv0, err0;
    logic [7:0] b;
    bus.i_Rx_DV = 1'b0; bus.i_Rx_Byte = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_phase", bus.o_phase_inc, DEF_INC);
    check("rst_busy", bus.o_busy, 0);
    check("rst_txdv", bus.o_Tx_DV, 0);
    check("rst_txbyte", bus.o_Tx_Byte, 0);
    check("rst_err", bus.o_err, 0);
    repeat (5) @(negedge clk);
    check("rst_no_pv", n_pv, 0);

    // Directed load and readback.
    load_and_check("load1", 64'h0123456789ABCDEF, 120, -1);
    query_and_check("query1", 1'b1);

    // Timeout after three payload bytes.
    pv0 = n_pv; err0 = n_err;
    got_tx.delete();
    send_byte(8'h46, 50, t);
    send_byte(8'h11, 70, t);
    send_byte(8'h22, 90, t);
    send_byte(8'h33, 2, t);
    wait_idle("tmo");
    check("tmo_err_count", n_err - err0, 1);
    check("tmo_err_cycle", err_cyc, t + TO);
    check("tmo_phase", bus.o_phase_inc, model_inc);
    check("tmo_no_pv", n_pv - pv0, 0);
    check("tmo_no_tx", got_tx.size(), 0);
    query_and_check("tmo_query", 1'b0);

    // Transmitter held busy: ack deferred until it frees up.
    @(posedge clk); #1 hold_act = 1'b1; t0 = cyc;
    pv0 = n_pv;
    got_tx.delete(); got_tx_cyc.delete();
    cmd_load({$urandom, $urandom}, 30, -1, t);
    @(negedge clk);
    check("hold_pv_count", n_pv - pv0, 1);
    check("hold_pv_latency", pv_cyc, t + 1);
    check("hold_phase", bus.o_phase_inc, model_inc);
    while (cyc < t0 + 500) @(posedge clk);
    #1;
    check("hold_no_tx_yet", got_tx.size(), 0);
    hold_act = 1'b0; rel = cyc;
    wait_idle("hold");
    check("hold_dv_cycle", (got_tx_cyc.size() > 0) ? got_tx_cyc[0] : -1, rel);
    exp_tx.delete(); exp_tx.push_back(ACK);
    compare_tx("hold_ack");

    // Byte arriving on the timeout cycle is accepted.
    load_and_check("bytewins", {$urandom, $urandom}, 40, $urandom_range(0, 6));
    query_and_check("bytewins_q", 1'b0);

    // Randomized loads and readbacks with stray bytes in IDLE.
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h46 || b == 8'h51) b = 8'h00;
      got_tx.delete();
      send_byte(b, 20, t);
      check("stray_busy", bus.o_busy, 0);
      check("stray_no_tx", got_tx.size(), 0);
      load_and_check("rnd_load", {$urandom, $urandom}, 200, -1);
      query_and_check("rnd_query", n[0]);
    end

    // Reset in the middle of a load.
    pv0 = n_pv; err0 = n_err;
    send_byte(8'h46, 10, t);
    send_byte(8'hAA, 10, t);
    send_byte(8'hBB, 5, t);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_inc = DEF_INC;
    @(negedge clk);
    check("mrst_phase", bus.o_phase_inc, DEF_INC);
    check("mrst_busy", bus.o_busy, 0);
    check("mrst_no_pv", n_pv - pv0, 0);
    check("mrst_no_err", n_err - err0, 0);
    load_and_check("mrst_load", {$urandom, $urandom}, 100, -1);

    // Unknown byte 0x00 in IDLE: no response at all.
    pv0 = n_pv; got_tx.delete();
    send_byte(8'h00, 50, t);
    check("zero_busy", bus.o_busy, 0);
    check("zero_no_tx", got_tx.size(), 0);
    check("zero_no_pv", n_pv - pv0, 0);
    query_and_check("final_q", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
